// File: rtl/adder.sv
// Registered ripple-carry adder: sign-extended sum and carry-out, one-cycle latency.
// Define ADDER_OVF_EN to add the registered signed-overflow output ovf.
module adder_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);
endmodule

module adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             c_in,
  output logic [WIDTH:0]   sum,
  output logic             c_out
`ifdef ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;
  logic [WIDTH:0]   sum_d;

  assign c[0] = c_in;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    adder_fa u_fa (
      .a  (A[i]),
      .b  (B[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

  // Top bit is the true sign of the exact (WIDTH+1)-bit result
  assign sum_d = {A[WIDTH-1] ^ B[WIDTH-1] ^ c[WIDTH], s};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum   <= '0;
      c_out <= 1'b0;
    end else begin
      sum   <= sum_d;
      c_out <= c[WIDTH];
    end
  end

`ifdef ADDER_OVF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ovf <= 1'b0;
    else      ovf <= c[WIDTH] ^ c[WIDTH-1];
  end
`endif

endmodule

// File: tb/tb_adder.sv
// Scoreboard bench for adder: driver pushes model results, monitor pops and
// compares one edge later. Covers reset, directed corners and random vectors.
module tb_adder;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic [W:0]   sum;
  logic         c_out;
`ifdef ADDER_OVF_EN
  logic         ovf;
`endif

  typedef struct {
    int s;
    bit co;
    bit ov;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .A     (a),
    .B     (b),
    .c_in  (cin),
    .sum   (sum),
    .c_out (c_out)
`ifdef ADDER_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(string name, int act, int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic exp_t model(logic [W-1:0] x, logic [W-1:0] y, logic ci);
    exp_t e;
    int   u;
    e.s  = int'($signed(x)) + int'($signed(y)) + int'(ci);
    u    = int'(x) + int'(y) + int'(ci);
    e.co = (u >= (1 << W));
    e.ov = (e.s > (1 << (W-1)) - 1) || (e.s < -(1 << (W-1)));
    return e;
  endfunction

  task automatic apply(logic [W-1:0] x, logic [W-1:0] y, logic ci);
    a   = x;
    b   = y;
    cin = ci;
    q.push_back(model(x, y, ci));
  endtask

  task automatic step(logic [W-1:0] x, logic [W-1:0] y, logic ci);
    @(negedge clk);
    apply(x, y, ci);
  endtask

  // Monitor: one result per edge, so each entry must appear exactly one edge later
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rst && q.size() > 0) begin
      e = q.pop_front();
      chk("sum", int'($signed(sum)), e.s);
      chk("c_out", int'(c_out), int'(e.co));
`ifdef ADDER_OVF_EN
      chk("ovf", int'(ovf), int'(e.ov));
`endif
    end
  end

  task automatic chk_reset(string tag);
    chk({tag, "_sum"}, int'(sum), 0);
    chk({tag, "_c_out"}, int'(c_out), 0);
`ifdef ADDER_OVF_EN
    chk({tag, "_ovf"}, int'(ovf), 0);
`endif
  endtask

  initial begin
    a = 8'hFF;
    b = 8'hFF;
    #1 rst = 1'b0;
    #1 chk_reset("rst_async");
    repeat (2) @(posedge clk);
    #1 chk_reset("rst_hold");

    @(negedge clk);
    rst = 1'b1;
    apply(8'hFF, 8'hFF, 1'b0);
    step(8'h08, 8'hFB, 1'b0);
    step(8'hFF, 8'hFF, 1'b0);
    step(8'h80, 8'hFF, 1'b0);
    step(8'h7F, 8'h01, 1'b0);
    step(8'hC0, 8'h20, 1'b0);
    step(8'hC0, 8'h20, 1'b1);
    step(8'h80, 8'h80, 1'b1);
    step(8'h80, 8'h80, 1'b0);
    step(8'h7F, 8'h7F, 1'b1);
    step(8'h00, 8'h00, 1'b0);
    step(8'hFF, 8'h01, 1'b0);

    for (int i = 0; i < 100; i++)
      step(W'($urandom), W'($urandom), 1'($urandom));

    @(posedge clk);
    #2 rst = 1'b0;
    #1 chk_reset("rst_mid");
    chk("q_empty_at_reset", q.size(), 0);

    @(negedge clk);
    rst = 1'b1;
    apply(8'h12, 8'h34, 1'b1);
    for (int i = 0; i < 100; i++)
      step(W'($urandom), W'($urandom), 1'($urandom));

    repeat (2) @(posedge clk);
    #3 chk("q_drained", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
